// File: rtl/cla_serial_adder_ctrl_if.sv
// Valid/ready bundle between the operand source, the nibble-serial adder and the result consumer.
interface cla_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, c_in, op_sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, op_sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, busy
    );
endinterface

// File: rtl/cla_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one reused 4-bit carry-lookahead slice,
// one nibble per cycle, LSB nibble first, with valid/ready on both sides.
module cla_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla_serial_adder_ctrl_if.slave  bus_if
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d;

    logic [3:0] sl_p, sl_g, sl_sum;
    logic [4:0] sl_c;

    // Single 4-bit lookahead slice fed from the low nibbles of the shift registers.
    assign sl_p    = a_q[3:0] ^ b_q[3:0];
    assign sl_g    = a_q[3:0] & b_q[3:0];
    assign sl_c[0] = carry_q;
    assign sl_c[1] = sl_g[0] | (sl_p[0] & carry_q);
    assign sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry_q);
    assign sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                   | (sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
    assign sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                   | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                   | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
    assign sl_sum  = sl_p ^ sl_c[3:0];

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    // Subtract is a + ~b + ~borrow, so invert B and the carry-in here.
                    a_d     = bus_if.a;
                    b_d     = bus_if.op_sub ? ~bus_if.b : bus_if.b;
                    carry_d = bus_if.c_in ^ bus_if.op_sub;
                    cnt_d   = '0;
                    a_msb_d = bus_if.a[WIDTH-1];
                    b_msb_d = bus_if.b[WIDTH-1] ^ bus_if.op_sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {sl_sum, res_q[WIDTH-1:4]};
                a_d     = {4'b0, a_q[WIDTH-1:4]};
                b_d     = {4'b0, b_q[WIDTH-1:4]};
                carry_d = sl_c[4];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {sl_sum, res_q[WIDTH-1:4]};
                    c_out_d = sl_c[4];
                    ovf_d   = (a_msb_q == b_msb_q) && (sl_sum[3] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus_if.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset as well, since sum and flags must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus_if.in_ready  = (state_q == IDLE) && rst_n;
    assign bus_if.out_valid = (state_q == DONE);
    assign bus_if.busy      = (state_q != IDLE);
    assign bus_if.sum       = sum_q;
    assign bus_if.c_out     = c_out_q;
    assign bus_if.overflow  = ovf_q;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Self-checking bench for cla_serial_adder_ctrl: vector table, random model vectors,
// backpressure and mid-run reset, with a scoreboard queue of expected results.
module tb_cla_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         op;
        exp_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_serial_adder_ctrl_if #(.WIDTH(W)) bus();
    cla_serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic op);
        logic [W:0] r;
        exp_t e;
        if (!op) r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        else     r = {1'b0, a} + {1'b0, ~b} + (W+1)'(!ci);
        e.sum  = r[W-1:0];
        e.cout = r[W];
        if (!op) e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        else     e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic start_txn(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                             input logic ci, input logic op, input exp_t e);
        int waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.c_in     = ci;
        bus.op_sub   = op;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.c_in     = ~ci;
        bus.op_sub   = ~op;
    endtask

    task automatic wait_result(input string tag);
        int   lat  = 0;
        bit   leak = 1'b0;
        exp_t e;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, NIB);
        check({tag, "_ready_low_during_run"}, leak, 0);
        check({tag, "_ready_low_in_done"}, bus.in_ready, 0);
        check({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, bus.sum, e.sum);
            check({tag, "_c_out"}, bus.c_out, e.cout);
            check({tag, "_overflow"}, bus.overflow, e.ovf);
        end
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_in_ready_after_release"}, bus.in_ready, 1);
        check({tag, "_out_valid_after_release"}, bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        logic [W-1:0] ra, rb, held_sum;
        logic       rc, rop, held_c, held_v;
        bit         bad;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000E, 1'b1, 1'b0}};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_c_out", bus.c_out, 0);
        check("rst_overflow", bus.overflow, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_txn(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].op, vecs[i].exp);
            wait_result($sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            rop = 1'($urandom);
            start_txn(ra, rb, rc, rop, model(ra, rb, rc, rop));
            wait_result($sformatf("rand%0d", i));
            release_result($sformatf("rand%0d", i));
        end

        // Backpressure: hold DONE for 5 cycles while the source keeps requesting.
        start_txn(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        wait_result("bp");
        held_sum = bus.sum;
        held_c   = bus.c_out;
        held_v   = bus.overflow;
        bad      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.sum !== held_sum || bus.c_out !== held_c ||
                bus.overflow !== held_v || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
                bad = 1'b1;
        end
        check("bp_hold_stable", bad, 0);
        check("bp_sum_held", bus.sum, 16'h3333);
        bus.a         = 16'hABCD;
        bus.b         = 16'h1234;
        bus.c_in      = 1'b0;
        bus.op_sub    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        sb_q.push_back(model(16'hABCD, 16'h1234, 1'b0, 1'b1));
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after_release", bus.in_ready, 1);
        check("bp_out_valid_after_release", bus.out_valid, 0);
        check("bp_sum_stable_in_idle", bus.sum, held_sum);
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op_sub   = 1'b0;
        wait_result("bp_next");
        check("bp_next_sum_value", bus.sum, 16'h9999);
        release_result("bp_next");

        // Reset two cycles into RUN aborts with no result.
        start_txn(16'h0F0F, 16'h0101, 1'b0, 1'b0, model(16'h0F0F, 16'h0101, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", bus.out_valid, 0);
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_sum", bus.sum, 0);
        check("midrun_rst_c_out", bus.c_out, 0);
        check("midrun_rst_in_ready", bus.in_ready, 0);
        sb_q.delete();
        @(negedge clk);
        check("in_reset_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        start_txn(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
        wait_result("post_rst");
        release_result("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_serial_adder_ctrl.md
# cla_serial_adder_ctrl

Multi-cycle wide adder/subtractor that reuses one 4-bit carry-lookahead slice (inputs a[3:0], b[3:0], c_in; outputs sum[3:0], c_out) and processes WIDTH-bit operands one nibble per cycle, least significant nibble first. It owns the operand/result shift registers, the inter-nibble carry register and the control FSM. Valid/ready handshakes on both sides let it sit between an operand source and a result consumer, trading latency for area against a full-width CLA.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8, otherwise elaboration fails. NIB = WIDTH/4.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE with rst_n high.
- a  input  WIDTH  operand A, sampled at accept only.
- b  input  WIDTH  operand B, sampled at accept only.
- c_in  input  1  carry-in (add) or borrow-in (subtract), sampled at accept.
- op_sub  input  1  0 = a+b+c_in; 1 = a-b-c_in. Sampled at accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (subtract: 1 = no borrow).
- overflow  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. Accept on in_valid&in_ready. Load a into the A shift register and ~b (op_sub=1) or b (op_sub=0) into the B shift register. Load carry = c_in ^ op_sub. Clear nibble counter cnt (width clog2(NIB)). Latch op_sub and the effective B MSB. Go to RUN.
- RUN, each cycle:
  - Slice inputs: low nibbles of A and B, plus carry.
  - Shift slice sum into the top of the result shift register. Shift A and B right by 4.
  - Update carry with slice c_out.
  - Increment cnt.
- RUN completion, when cnt==NIB-1:
  - Copy the completed result into the sum output register.
  - Register c_out = final carry.
  - Register overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb), where a_msb is the latched A MSB.
  - Go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE.
- Output holding:
  - sum, c_out and overflow change only at RUN completion.
  - They stay stable through DONE and afterwards until the next completion.
  - Partial RUN state is never visible on sum.
- While not in IDLE, in_valid is ignored and no operand is sampled. Changes on a, b, c_in and op_sub after accept have no effect.
- Subtract semantics: c_in=1 means borrow-in. Result is a - b - c_in mod 2^WIDTH. c_out=0 indicates a borrow.

## Timing
- Reset values: state IDLE, out_valid 0, busy 0, sum 0, c_out 0, overflow 0, cnt 0, carry 0, shift registers 0. in_ready is 0 while rst_n is low.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately, with no result delivered. First accept is possible on the first edge after rst_n rises.
- Latency: if accept is at edge E0, RUN occupies edges E1..E_NIB and out_valid is high after edge E_NIB. For WIDTH=16, out_valid is seen 4 cycles after accept.
- Handshake in DONE:
  - out_valid&out_ready at edge Ek returns the FSM to IDLE, with in_ready high after Ek.
  - The earliest next accept is Ek+1.
  - Minimum issue interval is NIB+2 cycles.
- Backpressure: out_valid stays high and outputs stay stable indefinitely while out_ready=0.
- out_ready while not in DONE is ignored.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, c_in=0, op_sub=0 -> sum=0x5555, c_out=0, overflow=0. out_valid rises exactly 4 cycles after accept. in_ready=0 during RUN and DONE.
- a=0xFFFF, b=0x0001, c_in=0, add -> sum=0x0000, c_out=1, overflow=0 (carry chains through all 4 nibbles). Also a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, c_out=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, overflow=1.
- op_sub=1: a=0x0005, b=0x0007, c_in=0 -> sum=0xFFFE, c_out=0, overflow=0. Then a=0x8000, b=0x0001, c_in=0 -> sum=0x7FFF, c_out=1, overflow=1. Then a=0x0010, b=0x0001, c_in=1 -> sum=0x000E, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands and toggling a and b -> out_valid stays 1, sum and flags stay constant, no accept. Release out_ready -> in_ready=1 on the next cycle, and the next operand pair is accepted and computed correctly.
- Reset: assert rst_n=0 two cycles into RUN -> out_valid=0, busy=0, sum=0 immediately. After release, an accepted 0x00FF+0x0001 -> sum=0x0100 with normal latency.
